io_peripheral: RTL and testbench

Memory-mapped I/O slave on the data bus, directly downstream of the bus and processor. It serves processor read/write requests to the board I/O: LEDR, SW, KEY and HEX0–HEX5.
- Accepted requests complete with a fixed-latency, one-cycle Done pulse.
- Keys are synchronized and press events are latched into a sticky edge-capture register.
- HEX outputs are driven from registered hex-digit values through active-low seven-segment decode.

---
 rtl/io_peripheral_if.sv | 12 +
 rtl/io_peripheral.sv | 194 +++++++++++++++++++
 tb/tb_io_peripheral.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/io_peripheral_if.sv
// Processor data-bus request/completion signals between the master and an I/O slave.
interface io_peripheral_if;
  logic        read;
  logic        write;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        done;

  modport master (output read, write, addr, wr_data, input rd_data, done);
  modport slave  (input read, write, addr, wr_data, output rd_data, done);
endinterface

// File: rtl/io_peripheral.sv
// Memory-mapped board I/O slave: Done pulses 3 cycles after a request is seen; a held request waits in RELEASE until dropped.
// Optional free-running TIMER register at offset 6 is enabled by defining IO_TIMER_EN.
module io_peripheral #(
  parameter logic [15:0] BASE_ADDR = 16'h1000,
  parameter int          PRESCALE  = 50000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  io_peripheral_if.slave bus,
  input  logic [9:0]     sw_i,
  input  logic [3:0]     key_i,
  output logic [9:0]     ledr_o,
  output logic [6:0]     hex0_o,
  output logic [6:0]     hex1_o,
  output logic [6:0]     hex2_o,
  output logic [6:0]     hex3_o,
  output logic [6:0]     hex4_o,
  output logic [6:0]     hex5_o
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_RELEASE} state_t;

  state_t      state_q;
  logic [3:0]  off_q;
  logic [15:0] wdat_q;
  logic        is_wr_q;
  logic [15:0] rdat_q, rd_data_q;
  logic        done_q;

  logic [9:0]  led_q, led_d;
  logic [15:0] hexlo_q, hexlo_d;
  logic [7:0]  hexhi_q, hexhi_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [3:0]  keyedge_q, keyedge_d;
  logic [9:0]  sw_s1_q, sw_s2_q;
  logic [3:0]  key_s1_q, key_s2_q, key_prev_q;

  logic        req, hit, wr_acc;
  logic [3:0]  press;
  logic [15:0] rd_mux, timer_rd;

  assign req    = bus.read | bus.write;
  assign hit    = (bus.addr[15:4] == BASE_ADDR[15:4]);
  assign wr_acc = (state_q == S_ACCESS) && is_wr_q;
  assign press  = key_prev_q & ~key_s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      off_q     <= '0;
      wdat_q    <= '0;
      is_wr_q   <= 1'b0;
      rdat_q    <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req && hit) begin
          off_q   <= bus.addr[3:0];
          wdat_q  <= bus.wr_data;
          is_wr_q <= bus.write;
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          rdat_q  <= is_wr_q ? 16'h0000 : rd_mux;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q    <= 1'b1;
          rd_data_q <= rdat_q;
          state_q   <= S_RELEASE;
        end
        S_RELEASE: if (!req) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (off_q)
      4'd0: rd_mux = {6'b0, led_q};
      4'd1: rd_mux = {6'b0, sw_s2_q};
      4'd2: rd_mux = hexlo_q;
      4'd3: rd_mux = {8'b0, hexhi_q};
      4'd4: rd_mux = {14'b0, ctrl_q};
      4'd5: rd_mux = {12'b0, keyedge_q};
      4'd6: rd_mux = timer_rd;
      default: rd_mux = 16'h0000;
    endcase
  end

  // A press in the same cycle as a W1C keeps the bit set.
  always_comb begin
    led_d     = led_q;
    hexlo_d   = hexlo_q;
    hexhi_d   = hexhi_q;
    ctrl_d    = ctrl_q;
    keyedge_d = keyedge_q;
    if (wr_acc) begin
      case (off_q)
        4'd0: led_d     = wdat_q[9:0];
        4'd2: hexlo_d   = wdat_q;
        4'd3: hexhi_d   = wdat_q[7:0];
        4'd4: ctrl_d    = wdat_q[1:0];
        4'd5: keyedge_d = keyedge_q & ~wdat_q[3:0];
        default: ;
      endcase
    end
    keyedge_d = keyedge_d | press;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q      <= '0;
      hexlo_q    <= '0;
      hexhi_q    <= '0;
      ctrl_q     <= '0;
      keyedge_q  <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      key_s1_q   <= 4'hF;
      key_s2_q   <= 4'hF;
      key_prev_q <= 4'hF;
    end else begin
      led_q      <= led_d;
      hexlo_q    <= hexlo_d;
      hexhi_q    <= hexhi_d;
      ctrl_q     <= ctrl_d;
      keyedge_q  <= keyedge_d;
      sw_s1_q    <= sw_i;
      sw_s2_q    <= sw_s1_q;
      key_s1_q   <= key_i;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
    end
  end

`ifdef IO_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   timer_q, timer_d;

  always_comb begin
    presc_d = presc_q;
    timer_d = timer_q;
    if (wr_acc && off_q == 4'd6) begin
      presc_d = '0;
      timer_d = '0;
    end else if (presc_q == PW'(PRESCALE - 1)) begin
      presc_d = '0;
      timer_d = timer_q + 16'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      timer_q <= '0;
    end else begin
      presc_q <= presc_d;
      timer_q <= timer_d;
    end
  end

  assign timer_rd = timer_q;
`else
  logic unused_presc;
  assign unused_presc = ^PRESCALE;
  assign timer_rd     = 16'h0000;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign hex0_o = ctrl_q[0] ? 7'h7F : seg7(hexlo_q[3:0]);
  assign hex1_o = ctrl_q[0] ? 7'h7F : seg7(hexlo_q[7:4]);
  assign hex2_o = ctrl_q[0] ? 7'h7F : seg7(hexlo_q[11:8]);
  assign hex3_o = ctrl_q[0] ? 7'h7F : seg7(hexlo_q[15:12]);
  assign hex4_o = ctrl_q[0] ? 7'h7F : seg7(hexhi_q[3:0]);
  assign hex5_o = ctrl_q[0] ? 7'h7F : seg7(hexhi_q[7:4]);

  assign ledr_o      = ctrl_q[1] ? sw_s2_q : led_q;
  assign bus.rd_data = rd_data_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_io_peripheral.sv
// Directed bench for io_peripheral: vector table for register accesses plus hand sequences for timing corners.
module tb_io_peripheral;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sw;
  logic [3:0] key;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  io_peripheral_if bus();

  io_peripheral #(.BASE_ADDR(16'h1000), .PRESCALE(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .sw_i(sw), .key_i(key), .ledr_o(ledr),
    .hex0_o(hex0), .hex1_o(hex1), .hex2_o(hex2), .hex3_o(hex3), .hex4_o(hex4), .hex5_o(hex5)
  );

  always #5 clk = ~clk;

  localparam logic [41:0] H_BASE = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [41:0] H_LO   = {7'h40, 7'h40, 7'h00, 7'h08, 7'h30, 7'h40};
  localparam logic [41:0] H_HI   = {7'h0E, 7'h79, 7'h00, 7'h08, 7'h30, 7'h40};
  localparam logic [41:0] H_CD   = {7'h46, 7'h21, 7'h00, 7'h08, 7'h30, 7'h40};
  localparam logic [41:0] H_BLK  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdat;
    logic [9:0]  sw;
    logic        chk;
    logic [15:0] exp_rd;
    logic [9:0]  exp_led;
    logic [41:0] exp_hex;
  } vec_t;

  vec_t tv[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [41:0] hex_now();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                           output logic [15:0] rdata, output int lat);
    bus.read = rd; bus.write = wr; bus.addr = a; bus.wr_data = d;
    lat = -1; rdata = 16'h0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = i; rdata = bus.rd_data; break; end
    end
    bus.read = 1'b0; bus.write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] r; int l;
    do_access(1'b1, 1'b0, a, 16'h0, r, l);
    check({name, "_lat"}, 64'(l), 64'(3));
    check(name, 64'(r), 64'(exp));
  endtask

  task automatic write_op(input string name, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] r; int l;
    do_access(1'b0, 1'b1, a, d, r, l);
    check({name, "_lat"}, 64'(l), 64'(3));
  endtask

  task automatic key_pulse(input int idx);
    key[idx] = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    key[idx] = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rdata;
    int lat, ndone;

    rst = 1'b1; sw = '0; key = 4'hF;
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ledr", 64'(ledr), 64'(0));
    check("rst_hex", 64'(hex_now()), 64'(H_BASE));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_rddata", 64'(bus.rd_data), 64'(0));

    //              name          rd wr addr      wdat      sw      chk exp_rd    led      hex
    tv.push_back('{"led_w",       0, 1, 16'h1000, 16'h03FF, 10'h000, 0, 16'h0000, 10'h3FF, H_BASE});
    tv.push_back('{"led_r",       1, 0, 16'h1000, 16'h0000, 10'h000, 1, 16'h03FF, 10'h3FF, H_BASE});
    tv.push_back('{"hexlo_w",     0, 1, 16'h1002, 16'h8A30, 10'h000, 0, 16'h0000, 10'h3FF, H_LO});
    tv.push_back('{"hexhi_w",     0, 1, 16'h1003, 16'h00F1, 10'h000, 0, 16'h0000, 10'h3FF, H_HI});
    tv.push_back('{"hexlo_r",     1, 0, 16'h1002, 16'h0000, 10'h000, 1, 16'h8A30, 10'h3FF, H_HI});
    tv.push_back('{"hexhi_r",     1, 0, 16'h1003, 16'h0000, 10'h000, 1, 16'h00F1, 10'h3FF, H_HI});
    tv.push_back('{"blank_w",     0, 1, 16'h1004, 16'h0001, 10'h000, 0, 16'h0000, 10'h3FF, H_BLK});
    tv.push_back('{"ctrl_r",      1, 0, 16'h1004, 16'h0000, 10'h000, 1, 16'h0001, 10'h3FF, H_BLK});
    tv.push_back('{"mirror_w",    0, 1, 16'h1004, 16'h0002, 10'h155, 0, 16'h0000, 10'h155, H_HI});
    tv.push_back('{"sw_r",        1, 0, 16'h1001, 16'h0000, 10'h155, 1, 16'h0155, 10'h155, H_HI});
    tv.push_back('{"sw_ro_w",     0, 1, 16'h1001, 16'hFFFF, 10'h155, 0, 16'h0000, 10'h155, H_HI});
    tv.push_back('{"mirror_off",  0, 1, 16'h1004, 16'h0000, 10'h155, 0, 16'h0000, 10'h3FF, H_HI});
    tv.push_back('{"rd_and_wr",   1, 1, 16'h1000, 16'h0012, 10'h155, 1, 16'h0000, 10'h012, H_HI});
    tv.push_back('{"led_hi_bits", 0, 1, 16'h1000, 16'hFC05, 10'h155, 0, 16'h0000, 10'h005, H_HI});
    tv.push_back('{"led_r2",      1, 0, 16'h1000, 16'h0000, 10'h155, 1, 16'h0005, 10'h005, H_HI});
    tv.push_back('{"unmapped_w",  0, 1, 16'h100F, 16'hFFFF, 10'h155, 0, 16'h0000, 10'h005, H_HI});
    tv.push_back('{"unmapped_r",  1, 0, 16'h1009, 16'h0000, 10'h155, 1, 16'h0000, 10'h005, H_HI});
    tv.push_back('{"hexhi_wide",  0, 1, 16'h1003, 16'hABCD, 10'h155, 0, 16'h0000, 10'h005, H_CD});
    tv.push_back('{"hexhi_r2",    1, 0, 16'h1003, 16'h0000, 10'h155, 1, 16'h00CD, 10'h005, H_CD});

    foreach (tv[i]) begin
      sw = tv[i].sw;
      do_access(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wdat, rdata, lat);
      check({tv[i].name, "_lat"}, 64'(lat), 64'(3));
      if (tv[i].chk) check({tv[i].name, "_rd"}, 64'(rdata), 64'(tv[i].exp_rd));
      check({tv[i].name, "_ledr"}, 64'(ledr), 64'(tv[i].exp_led));
      check({tv[i].name, "_hex"}, 64'(hex_now()), 64'(tv[i].exp_hex));
    end

    // Held read is served exactly once.
    sw = 10'h155;
    bus.read = 1'b1; bus.addr = 16'h1001; ndone = 0; rdata = 16'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin ndone++; rdata = bus.rd_data; end
    end
    bus.read = 1'b0;
    @(posedge clk); #1;
    check("held_done_count", 64'(ndone), 64'(1));
    check("held_rd", 64'(rdata), 64'(16'h0155));
    check("rd_hold", 64'(bus.rd_data), 64'(16'h0155));

    // Address misses never complete and change nothing.
    bus.read = 1'b1; bus.write = 1'b1; bus.addr = 16'h2000; bus.wr_data = 16'h0000; ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    bus.read = 1'b0; bus.write = 1'b0;
    @(posedge clk); #1;
    check("miss_done_count", 64'(ndone), 64'(0));
    check("miss_ledr", 64'(ledr), 64'(10'h005));

    // Addr/data change after capture is ignored.
    bus.write = 1'b1; bus.addr = 16'h1000; bus.wr_data = 16'h0055; lat = -1;
    @(posedge clk); #1;
    bus.addr = 16'h1002; bus.wr_data = 16'hFFFF;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = i; break; end
    end
    bus.write = 1'b0;
    @(posedge clk); #1;
    check("late_chg_lat", 64'(lat), 64'(3));
    check("late_chg_ledr", 64'(ledr), 64'(10'h055));
    check("late_chg_hex", 64'(hex_now()), 64'(H_CD));

    // Key edge capture and W1C.
    key_pulse(1);
    read_chk("key_press1", 16'h1005, 16'h0002);
    write_op("key_w1c", 16'h1005, 16'h0002);
    read_chk("key_cleared", 16'h1005, 16'h0000);
    key_pulse(1);
    read_chk("key_press2", 16'h1005, 16'h0002);
    write_op("key_w1c_other", 16'h1005, 16'h0001);
    read_chk("key_w1c_other", 16'h1005, 16'h0002);
    key[1] = 1'b0;
    @(posedge clk); #1;
    write_op("key_coincide_w", 16'h1005, 16'h0002);
    read_chk("key_coincide", 16'h1005, 16'h0002);
    key[1] = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    write_op("key_w1c2", 16'h1005, 16'h0002);
    read_chk("key_cleared2", 16'h1005, 16'h0000);

    // Reset during ACCESS aborts the write.
    bus.write = 1'b1; bus.addr = 16'h1000; bus.wr_data = 16'h00AA;
    @(posedge clk); #1;
    rst = 1'b1; bus.write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; ndone = 0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("rst_abort_done", 64'(ndone), 64'(0));
    check("rst_abort_ledr", 64'(ledr), 64'(0));
    check("rst_abort_hex", 64'(hex_now()), 64'(H_BASE));
    check("rst_abort_rd", 64'(bus.rd_data), 64'(0));

`ifdef IO_TIMER_EN
    read_chk("timer_12cyc", 16'h1006, 16'h0003);
`else
    read_chk("timer_absent", 16'h1006, 16'h0000);
`endif
    write_op("timer_clr", 16'h1006, 16'h1234);
    read_chk("timer_after_clr", 16'h1006, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
